// File: rtl/game_pkg.sv
// Shared game constants: state encoding, level width and default ball timing.
// Imported by the tick scheduler, ball and score blocks.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE  = 2'd1,
        ST_RALLY  = 2'd2,
        ST_PAUSED = 2'd3
    } game_state_t;

    localparam int LEVEL_W       = 4;
    localparam int MAX_LEVEL_CAP = 15;

    localparam int DEF_PERIOD_WIDTH   = 20;
    localparam int DEF_BASE_PERIOD    = 500000;
    localparam int DEF_MIN_PERIOD     = 100000;
    localparam int DEF_PERIOD_STEP    = 50000;
    localparam int DEF_HITS_PER_LEVEL = 4;
    localparam int DEF_SERVE_STEPS    = 100;

endpackage

// File: rtl/period_prescaler.sv
// Counts 0..period-1 with a runtime period; wrap flags the last count of each cycle.
// Latency: wrap is combinational from the count register; count returns to 0 on the next edge.
// Backpressure: none; enable low freezes the count, clear forces it to 0.
module period_prescaler #(
    parameter int WIDTH = 20
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] period,
    input  logic             enable,
    input  logic             clear,
    output logic             wrap
);

    logic [WIDTH-1:0] count;

    assign wrap = enable && (count == period - WIDTH'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || wrap) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/rally_tick_scheduler.sv
// Ball timebase: serve/rally/pause FSM driving a prescaler whose period shrinks with speed level.
// Latency: step_tick and serve_ready are registered, one cycle after the prescaler wrap.
// Backpressure: none; event pulses are consumed the cycle they arrive, by fixed priority.
module rally_tick_scheduler
    import game_pkg::*;
#(
    parameter int PERIOD_WIDTH   = DEF_PERIOD_WIDTH,
    parameter int BASE_PERIOD    = DEF_BASE_PERIOD,
    parameter int MIN_PERIOD     = DEF_MIN_PERIOD,
    parameter int PERIOD_STEP    = DEF_PERIOD_STEP,
    parameter int HITS_PER_LEVEL = DEF_HITS_PER_LEVEL,
    parameter int SERVE_STEPS    = DEF_SERVE_STEPS
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    pause_toggle,
    input  logic                    hit,
    input  logic                    miss,
    output logic                    step_tick,
    output logic                    serve_ready,
    output logic [1:0]              state,
    output logic [LEVEL_W-1:0]      level,
    output logic [PERIOD_WIDTH-1:0] period
);

    localparam int MAX_RAW   = (BASE_PERIOD - MIN_PERIOD) / PERIOD_STEP;
    localparam int MAX_LEVEL = (MAX_RAW > MAX_LEVEL_CAP) ? MAX_LEVEL_CAP : MAX_RAW;
    localparam int SCW       = $clog2(SERVE_STEPS + 1);
    localparam int HCW       = $clog2(HITS_PER_LEVEL + 1);
    localparam int PW4       = PERIOD_WIDTH + 4;

    game_state_t       cur_st;
    game_state_t       ret_st;
    logic [SCW-1:0]    serve_cnt;
    logic [HCW-1:0]    hit_cnt;
    logic              wrap;

    logic do_stop, do_miss, do_pause, do_hit, do_start;
    logic pre_en, pre_clr;

    // Widened product so high levels saturate to MIN_PERIOD instead of underflowing.
    logic [PW4-1:0]          lvl_prod;
    logic [PERIOD_WIDTH-1:0] target;

    assign lvl_prod = PW4'(level) * PW4'(PERIOD_STEP);
    assign target   = (lvl_prod >= PW4'(BASE_PERIOD - MIN_PERIOD)) ?
                      PERIOD_WIDTH'(MIN_PERIOD) :
                      PERIOD_WIDTH'(PW4'(BASE_PERIOD) - lvl_prod);

    assign do_stop  = stop;
    assign do_miss  = miss && (cur_st == ST_RALLY) && !stop;
    assign do_pause = pause_toggle && (cur_st != ST_IDLE) && !stop && !do_miss;
    assign do_hit   = hit && (cur_st == ST_RALLY) && !stop && !miss && !pause_toggle;
    assign do_start = start && (cur_st == ST_IDLE) && !stop;

    // Freezing on the pause cycle itself keeps the resumed cycle length exact.
    assign pre_en  = ((cur_st == ST_SERVE) || (cur_st == ST_RALLY)) && !do_stop && !do_miss && !do_pause;
    assign pre_clr = (cur_st == ST_IDLE) || do_stop || do_miss || do_start;

    period_prescaler #(
        .WIDTH (PERIOD_WIDTH)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .period  (period),
        .enable  (pre_en),
        .clear   (pre_clr),
        .wrap    (wrap)
    );

    assign state = cur_st;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_st      <= ST_IDLE;
            ret_st      <= ST_SERVE;
            level       <= '0;
            hit_cnt     <= '0;
            serve_cnt   <= '0;
            period      <= PERIOD_WIDTH'(BASE_PERIOD);
            step_tick   <= 1'b0;
            serve_ready <= 1'b0;
        end else begin
            step_tick   <= (cur_st == ST_RALLY) && wrap;
            serve_ready <= (cur_st == ST_SERVE) && wrap && (serve_cnt == SCW'(1));
            if (wrap) begin
                period <= target;
            end
            if (do_stop) begin
                cur_st  <= ST_IDLE;
                level   <= '0;
                hit_cnt <= '0;
                period  <= PERIOD_WIDTH'(BASE_PERIOD);
            end else if (do_start || do_miss) begin
                cur_st    <= ST_SERVE;
                serve_cnt <= SCW'(SERVE_STEPS);
                level     <= '0;
                hit_cnt   <= '0;
                period    <= PERIOD_WIDTH'(BASE_PERIOD);
            end else if (do_pause) begin
                if (cur_st == ST_PAUSED) begin
                    cur_st <= ret_st;
                end else begin
                    ret_st <= cur_st;
                    cur_st <= ST_PAUSED;
                end
            end else begin
                if (do_hit) begin
                    if (hit_cnt == HCW'(HITS_PER_LEVEL - 1)) begin
                        hit_cnt <= '0;
                        if (level < LEVEL_W'(MAX_LEVEL)) begin
                            level <= level + LEVEL_W'(1);
                        end
                    end else begin
                        hit_cnt <= hit_cnt + HCW'(1);
                    end
                end
                if (wrap && (cur_st == ST_SERVE)) begin
                    serve_cnt <= serve_cnt - SCW'(1);
                    if (serve_cnt == SCW'(1)) begin
                        cur_st <= ST_RALLY;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rally_tick_scheduler.sv
// Bench for rally_tick_scheduler with small timing constants: vector table, corner sequences,
// and randomized events checked cycle by cycle against a countdown-based reference model.
module tb_rally_tick_scheduler;

    localparam int PW     = 20;
    localparam int BASE   = 10;
    localparam int MINP   = 4;
    localparam int STEP   = 2;
    localparam int HPL    = 2;
    localparam int SSTEPS = 3;
    localparam int MAXL   = ((BASE - MINP) / STEP > 15) ? 15 : (BASE - MINP) / STEP;

    logic          clock;
    logic          reset_n;
    logic          start, stop, pause_toggle, hit, miss;
    logic          step_tick, serve_ready;
    logic [1:0]    state;
    logic [3:0]    level;
    logic [PW-1:0] period;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: mleft = cycles remaining in the current step including this one.
    int ms, mret, mlvl, mhits, mper, mleft, mserve;
    bit mtick, mready;

    typedef struct {
        bit s, p, h;
        int n;
        int st, lvl, per;
        bit tick, rdy;
    } vec_t;
    vec_t tbl[$];

    rally_tick_scheduler #(
        .PERIOD_WIDTH   (PW),
        .BASE_PERIOD    (BASE),
        .MIN_PERIOD     (MINP),
        .PERIOD_STEP    (STEP),
        .HITS_PER_LEVEL (HPL),
        .SERVE_STEPS    (SSTEPS)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .pause_toggle (pause_toggle),
        .hit          (hit),
        .miss         (miss),
        .step_tick    (step_tick),
        .serve_ready  (serve_ready),
        .state        (state),
        .level        (level),
        .period       (period)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic vec_t v(bit s, bit p, bit h, int n, int st, int lvl, int per, bit tick, bit rdy);
        vec_t r;
        r.s = s; r.p = p; r.h = h; r.n = n;
        r.st = st; r.lvl = lvl; r.per = per; r.tick = tick; r.rdy = rdy;
        return r;
    endfunction

    function automatic int tgt(int lvl);
        int p;
        p = BASE - lvl * STEP;
        return (p < MINP) ? MINP : p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0d required %0d", nm, $time, act, exp);
        end
    endtask

    task automatic mdl_reset();
        ms = 0; mret = 1; mlvl = 0; mhits = 0; mper = BASE; mleft = BASE; mserve = 0;
        mtick = 0; mready = 0;
    endtask

    task automatic mdl_step(input bit s, input bit sp, input bit pt, input bit h, input bit m);
        bit active, lose, tog, bump, fire;
        active = (ms == 1) || (ms == 2);
        lose   = !sp && m && (ms == 2);
        tog    = !sp && !lose && pt && (ms != 0);
        bump   = !sp && !lose && !pt && h && (ms == 2);
        fire   = active && !sp && !lose && !tog && (mleft == 1);
        mtick  = fire && (ms == 2);
        mready = fire && (ms == 1) && (mserve == 1);
        if (sp) begin
            ms = 0; mlvl = 0; mhits = 0; mper = BASE; mleft = BASE;
        end else if (lose || (s && ms == 0)) begin
            ms = 1; mserve = SSTEPS; mlvl = 0; mhits = 0; mper = BASE; mleft = BASE;
        end else if (tog) begin
            if (ms == 3) ms = mret;
            else begin mret = ms; ms = 3; end
        end else if (active) begin
            if (fire) begin
                mper  = tgt(mlvl);
                mleft = mper;
                if (ms == 1) begin
                    mserve--;
                    if (mserve == 0) ms = 2;
                end
            end else begin
                mleft--;
            end
            if (bump) begin
                mhits++;
                if (mhits == HPL) begin
                    mhits = 0;
                    if (mlvl < MAXL) mlvl++;
                end
            end
        end
    endtask

    task automatic cyc(input bit s, input bit sp, input bit pt, input bit h, input bit m);
        start = s; stop = sp; pause_toggle = pt; hit = h; miss = m;
        @(posedge clock);
        mdl_step(s, sp, pt, h, m);
        @(negedge clock);
        start = 0; stop = 0; pause_toggle = 0; hit = 0; miss = 0;
        chk("model_state", 32'(state), ms);
        chk("model_level", 32'(level), mlvl);
        chk("model_period", 32'(period), mper);
        chk("model_step_tick", 32'(step_tick), 32'(mtick));
        chk("model_serve_ready", 32'(serve_ready), 32'(mready));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        int guard;
        int ticks;
        reset_n = 0; start = 0; stop = 0; pause_toggle = 0; hit = 0; miss = 0;
        mdl_reset();
        repeat (3) @(negedge clock);
        chk("rst_state", 32'(state), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_period", 32'(period), BASE);
        chk("rst_step_tick", 32'(step_tick), 0);
        chk("rst_serve_ready", 32'(serve_ready), 0);
        reset_n = 1;

        // serve delay and first rally ticks
        tbl.push_back(v(1,0,0,  1, 1,0,10,0,0));
        tbl.push_back(v(0,0,0, 29, 1,0,10,0,0));
        tbl.push_back(v(0,0,0,  1, 2,0,10,0,1));
        tbl.push_back(v(0,0,0,  9, 2,0,10,0,0));
        tbl.push_back(v(0,0,0,  1, 2,0,10,1,0));
        tbl.push_back(v(0,0,0,  9, 2,0,10,0,0));
        tbl.push_back(v(0,0,0,  1, 2,0,10,1,0));
        // pause at count 5, hold 100 cycles, resume: tick 5 cycles later
        tbl.push_back(v(0,0,0,  5, 2,0,10,0,0));
        tbl.push_back(v(0,1,0,  1, 3,0,10,0,0));
        tbl.push_back(v(0,0,0,100, 3,0,10,0,0));
        tbl.push_back(v(0,1,0,  1, 2,0,10,0,0));
        tbl.push_back(v(0,0,0,  4, 2,0,10,0,0));
        tbl.push_back(v(0,0,0,  1, 2,0,10,1,0));
        // speed levels: 10 then 8 spacing, saturation at level 3 / period 4
        tbl.push_back(v(0,0,1,  1, 2,0,10,0,0));
        tbl.push_back(v(0,0,1,  1, 2,1,10,0,0));
        tbl.push_back(v(0,0,0,  7, 2,1,10,0,0));
        tbl.push_back(v(0,0,0,  1, 2,1, 8,1,0));
        tbl.push_back(v(0,0,0,  7, 2,1, 8,0,0));
        tbl.push_back(v(0,0,0,  1, 2,1, 8,1,0));
        tbl.push_back(v(0,0,1,  1, 2,1, 8,0,0));
        tbl.push_back(v(0,0,1,  1, 2,2, 8,0,0));
        tbl.push_back(v(0,0,1,  1, 2,2, 8,0,0));
        tbl.push_back(v(0,0,1,  1, 2,3, 8,0,0));
        tbl.push_back(v(0,0,1,  1, 2,3, 8,0,0));
        tbl.push_back(v(0,0,1,  1, 2,3, 8,0,0));
        tbl.push_back(v(0,0,0,  1, 2,3, 8,0,0));
        tbl.push_back(v(0,0,0,  1, 2,3, 4,1,0));
        tbl.push_back(v(0,0,0,  3, 2,3, 4,0,0));
        tbl.push_back(v(0,0,0,  1, 2,3, 4,1,0));
        tbl.push_back(v(0,0,1,  1, 2,3, 4,0,0));
        tbl.push_back(v(0,0,1,  1, 2,3, 4,0,0));
        tbl.push_back(v(0,0,0,  1, 2,3, 4,0,0));
        tbl.push_back(v(0,0,0,  1, 2,3, 4,1,0));

        foreach (tbl[i]) begin
            cyc(tbl[i].s, 0, tbl[i].p, tbl[i].h, 0);
            idle(tbl[i].n - 1);
            chk($sformatf("vec%0d_state", i), 32'(state), tbl[i].st);
            chk($sformatf("vec%0d_level", i), 32'(level), tbl[i].lvl);
            chk($sformatf("vec%0d_period", i), 32'(period), tbl[i].per);
            chk($sformatf("vec%0d_step_tick", i), 32'(step_tick), 32'(tbl[i].tick));
            chk($sformatf("vec%0d_serve_ready", i), 32'(serve_ready), 32'(tbl[i].rdy));
        end

        // hit+miss on a wrap at level 2
        cyc(0, 0, 0, 0, 1);
        chk("miss_state", 32'(state), 1);
        chk("miss_level", 32'(level), 0);
        guard = 0;
        while (ms != 2 && guard < 100) begin idle(1); guard++; end
        chk("reach_rally", 32'(state), 2);
        repeat (4) cyc(0, 0, 0, 1, 0);
        chk("lvl2_level", 32'(level), 2);
        guard = 0;
        while (mleft != 1 && guard < 20) begin idle(1); guard++; end
        cyc(0, 0, 0, 1, 1);
        chk("hitmiss_tick", 32'(step_tick), 0);
        chk("hitmiss_state", 32'(state), 1);
        chk("hitmiss_level", 32'(level), 0);
        chk("hitmiss_period", 32'(period), BASE);
        idle(29);
        chk("hitmiss_serve_state", 32'(state), 1);
        idle(1);
        chk("hitmiss_rally_state", 32'(state), 2);
        chk("hitmiss_ready", 32'(serve_ready), 1);

        // stop while paused from serve, then a full serve again
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        chk("pause_serve_state", 32'(state), 3);
        idle(5);
        cyc(0, 1, 0, 0, 0);
        chk("stop_state", 32'(state), 0);
        chk("stop_level", 32'(level), 0);
        chk("stop_period", 32'(period), BASE);
        idle(3);
        cyc(1, 0, 0, 0, 0);
        chk("restart_state", 32'(state), 1);
        idle(29);
        chk("restart_ready_early", 32'(serve_ready), 0);
        idle(1);
        chk("restart_ready", 32'(serve_ready), 1);
        chk("restart_rally", 32'(state), 2);

        // asynchronous reset mid-rally
        repeat (2) cyc(0, 0, 0, 1, 0);
        idle(3);
        chk("pre_reset_level", 32'(level), 1);
        #2 reset_n = 0;
        #1;
        chk("async_state", 32'(state), 0);
        chk("async_level", 32'(level), 0);
        chk("async_period", 32'(period), BASE);
        chk("async_step_tick", 32'(step_tick), 0);
        chk("async_serve_ready", 32'(serve_ready), 0);
        mdl_reset();
        repeat (2) @(negedge clock);
        reset_n = 1;
        ticks = 0;
        for (int k = 0; k < 40; k++) begin
            idle(1);
            ticks += int'(step_tick);
        end
        chk("no_tick_after_reset", 32'(ticks), 0);

        // randomized event traffic
        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 99) < 6, $urandom_range(0, 999) < 8,
                $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 12,
                $urandom_range(0, 99) < 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
